// File: rtl/iterative_shifter.sv
// Multicycle shift unit: SLL/SRL/SRA one bit per clock, start/done handshake.
// data_out only changes on entry to DONE and otherwise holds the last result.
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   work, work_next;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   data_out_next;
    logic [SHAMT_W-1:0] count, count_next;
    logic [1:0]         op_q, op_next;

    // One-bit step of the latched operation; pass-through never reaches SHIFT.
    always_comb begin
        shifted = work;
        case (op_q)
            2'b00:   shifted = {work[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work[WIDTH-1:1]};
            2'b10:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_next    = state;
        work_next     = work;
        count_next    = count;
        op_next       = op_q;
        data_out_next = data_out;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = data_in;
                    op_next    = op;
                    count_next = shamt;
                    if (shamt == '0 || op == 2'b11) begin
                        state_next    = DONE;
                        data_out_next = data_in;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next  = shifted;
                count_next = count - 1'b1;
                if (count == 1) begin
                    state_next    = DONE;
                    data_out_next = shifted;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            op_q     <= 2'b00;
            data_out <= '0;
        end else begin
            state    <= state_next;
            work     <= work_next;
            count    <= count_next;
            op_q     <= op_next;
            data_out <= data_out_next;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: vector table plus hand-written
// sequences for dropped starts and mid-shift reset.
module tb_iterative_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int total;
    int bad;
    logic [31:0] prev_exp;

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] din;
        logic [31:0] exp_out;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issues one start, then scrambles the inputs so late changes are visible.
    task automatic applyStimulus(input logic [1:0] v_op, input logic [4:0] v_shamt,
                                 input logic [31:0] v_din, output int lat,
                                 output logic [31:0] res, output bit busy_ok,
                                 output bit hold_ok);
        @(negedge clk);
        start   = 1'b1;
        op      = v_op;
        shamt   = v_shamt;
        data_in = v_din;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = ~v_op;
        shamt   = ~v_shamt;
        data_in = ~v_din;
        lat     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (data_out !== prev_exp) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        res = data_out;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        bit          hold_ok;
        int          done_cnt;
        int          done_cyc;
        bit          idle_ok;

        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        shamt   = 5'd0;
        data_in = 32'h0;

        vecs[0]  = '{2'b00, 5'd31, 32'h00000001, 32'h80000000, 32};
        vecs[1]  = '{2'b10, 5'd4,  32'h80000000, 32'hF8000000, 5};
        vecs[2]  = '{2'b01, 5'd4,  32'h80000000, 32'h08000000, 5};
        vecs[3]  = '{2'b01, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[4]  = '{2'b11, 5'd20, 32'hA5A5A5A5, 32'hA5A5A5A5, 1};
        vecs[5]  = '{2'b10, 5'd1,  32'h7FFFFFFF, 32'h3FFFFFFF, 2};
        vecs[6]  = '{2'b01, 5'd31, 32'h80000000, 32'h00000001, 32};
        vecs[7]  = '{2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 32};
        vecs[8]  = '{2'b00, 5'd31, 32'hFFFFFFFE, 32'h00000000, 32};
        vecs[9]  = '{2'b00, 5'd1,  32'hC0000001, 32'h80000002, 2};
        vecs[10] = '{2'b00, 5'd0,  32'h12345678, 32'h12345678, 1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset data_out", data_out, 32'h0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        prev_exp = 32'h0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].shamt, vecs[i].din, lat, res, busy_ok, hold_ok);
            checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d busy while active", i), {31'd0, busy_ok}, 32'd1);
            checkOutput($sformatf("vec%0d data_out held", i), {31'd0, hold_ok}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
            checkOutput($sformatf("vec%0d busy after", i), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("vec%0d result holds", i), data_out, vecs[i].exp_out);
            prev_exp = vecs[i].exp_out;
        end

        // Starts on cycle 3 (mid-shift) and cycle 9 (DONE) must both be dropped.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b00;
        shamt   = 5'd8;
        data_in = 32'h000000FF;
        done_cnt = 0;
        done_cyc = 0;
        idle_ok  = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc >= 10 && busy) idle_ok = 1'b0;
            if (cyc == 2 || cyc == 9) begin
                start   = 1'b1;
                shamt   = 5'd1;
                data_in = 32'h0;
            end
        end
        checkOutput("drop start result", data_out, 32'h0000FF00);
        checkOutput("drop start done count", done_cnt, 1);
        checkOutput("drop start done cycle", done_cyc, 9);
        checkOutput("drop start idle after", {31'd0, idle_ok}, 32'd1);
        prev_exp = 32'h0000FF00;

        // Reset mid-shift discards the operation.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b10;
        shamt   = 5'd16;
        data_in = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid reset data_out", data_out, 32'h0);
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid reset done", {31'd0, done}, 32'd0);
        done_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        checkOutput("no activity after reset", done_cnt, 0);
        prev_exp = 32'h0;

        applyStimulus(2'b00, 5'd2, 32'h00000001, lat, res, busy_ok, hold_ok);
        checkOutput("post-reset result", res, 32'h00000004);
        checkOutput("post-reset latency", lat, 3);
        checkOutput("post-reset data_out held", {31'd0, hold_ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
